// File: rtl/lcd_writer_if.sv
// Signal bundle between the LCD writer, the upstream character formatter and the HD44780 pins.
interface lcd_writer_if;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       frame_done;

    modport master (
        input  char_in,
        output index, lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
    );

    modport slave (
        output char_in,
        input  index, lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
    );
endinterface

// File: rtl/lcd_writer.sv
// HD44780 2x16 refresh engine: power-up wait, init commands, then continuously
// rewrites both lines from the formatter, one bus write per step of TICK_DIV clocks.
module lcd_writer #(
    parameter int TICK_DIV      = 50000,
    parameter int POWERUP_STEPS = 40,
    parameter int CLEAR_STEPS   = 2
) (
    input  logic          clk,
    input  logic          rst,
    lcd_writer_if.master  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(TICK_DIV / 2);
    localparam logic [15:0]   PWR_LAST  = 16'(POWERUP_STEPS - 1);
    localparam logic [15:0]   CLR_LAST  = 16'(CLEAR_STEPS - 1);
    localparam logic [15:0]   INIT_LAST = 16'd3;
    localparam logic [15:0]   LINE_LAST = 16'd15;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        CLR_WAIT = 3'd2,
        ADDR1    = 3'd3,
        DATA1    = 3'd4,
        ADDR2    = 3'd5,
        DATA2    = 3'd6
    } state_t;

    // Function set 8-bit/2-line, display on, entry increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] n);
        case (n)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            2'd3:    init_cmd = 8'h01;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    state_t        state_r, state_next_s;
    logic [PW-1:0] pcnt_r, pcnt_next_s;
    logic [15:0]   scnt_r, scnt_next_s;
    logic [4:0]    index_r, index_next_s;
    logic          rs_r, rs_next_s;
    logic [7:0]    data_r, data_next_s;
    logic          lcd_e_r, lcd_e_next_s;
    logic          frame_done_r, frame_done_next_s;
    logic          boundary_s;
    logic          write_state_s;

    // Step timer, strobe shaping and the step-boundary sequencer.
    always_comb begin
        state_next_s      = state_r;
        scnt_next_s       = scnt_r;
        index_next_s      = index_r;
        rs_next_s         = rs_r;
        data_next_s       = data_r;
        frame_done_next_s = 1'b0;
        boundary_s        = (pcnt_r == PCNT_LAST);
        pcnt_next_s       = boundary_s ? {PW{1'b0}} : pcnt_r + PW'(1'b1);

        case (state_r)
            INIT, ADDR1, DATA1, ADDR2, DATA2: write_state_s = 1'b1;
            default:                          write_state_s = 1'b0;
        endcase
        // Strobe is high for the cycles where pcnt will be 1..TICK_DIV/2.
        lcd_e_next_s = write_state_s && (pcnt_r < PCNT_HALF);

        if (boundary_s) begin
            case (state_r)
                PWR_WAIT: begin
                    if (scnt_r == PWR_LAST) begin
                        state_next_s = INIT;
                        scnt_next_s  = 16'd0;
                        rs_next_s    = 1'b0;
                        data_next_s  = init_cmd(2'd0);
                    end else begin
                        scnt_next_s  = scnt_r + 16'd1;
                    end
                end
                INIT: begin
                    if (scnt_r == INIT_LAST) begin
                        state_next_s = CLR_WAIT;
                        scnt_next_s  = 16'd0;
                    end else begin
                        scnt_next_s  = scnt_r + 16'd1;
                        data_next_s  = init_cmd(scnt_next_s[1:0]);
                    end
                end
                CLR_WAIT: begin
                    if (scnt_r == CLR_LAST) begin
                        state_next_s = ADDR1;
                        scnt_next_s  = 16'd0;
                        rs_next_s    = 1'b0;
                        data_next_s  = 8'h80;
                        index_next_s = 5'd0;
                    end else begin
                        scnt_next_s  = scnt_r + 16'd1;
                    end
                end
                ADDR1, ADDR2: begin
                    state_next_s = (state_r == ADDR1) ? DATA1 : DATA2;
                    scnt_next_s  = 16'd0;
                    rs_next_s    = 1'b1;
                    data_next_s  = bus.char_in;
                    index_next_s = index_r + 5'd1;
                end
                DATA1: begin
                    if (scnt_r == LINE_LAST) begin
                        state_next_s = ADDR2;
                        scnt_next_s  = 16'd0;
                        rs_next_s    = 1'b0;
                        data_next_s  = 8'hC0;
                        index_next_s = 5'd16;
                    end else begin
                        scnt_next_s  = scnt_r + 16'd1;
                        data_next_s  = bus.char_in;
                        index_next_s = index_r + 5'd1;
                    end
                end
                DATA2: begin
                    if (scnt_r == LINE_LAST) begin
                        state_next_s      = ADDR1;
                        scnt_next_s       = 16'd0;
                        rs_next_s         = 1'b0;
                        data_next_s       = 8'h80;
                        index_next_s      = 5'd0;
                        frame_done_next_s = 1'b1;
                    end else begin
                        scnt_next_s  = scnt_r + 16'd1;
                        data_next_s  = bus.char_in;
                        index_next_s = index_r + 5'd1;
                    end
                end
                default: begin
                    state_next_s = PWR_WAIT;
                    scnt_next_s  = 16'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= PWR_WAIT;
            pcnt_r       <= {PW{1'b0}};
            scnt_r       <= 16'd0;
            index_r      <= 5'd0;
            rs_r         <= 1'b0;
            data_r       <= 8'h00;
            lcd_e_r      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pcnt_r       <= pcnt_next_s;
            scnt_r       <= scnt_next_s;
            index_r      <= index_next_s;
            rs_r         <= rs_next_s;
            data_r       <= data_next_s;
            lcd_e_r      <= lcd_e_next_s;
            frame_done_r <= frame_done_next_s;
        end
    end

    assign bus.index      = index_r;
    assign bus.lcd_e      = lcd_e_r;
    assign bus.lcd_rs     = rs_r;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = data_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench for lcd_writer: expected LCD write stream is derived from the
// character table; a monitor pops and checks each strobe as it appears.
module tb_lcd_writer;
    localparam int TICK = 4;
    localparam int PWR  = 4;
    localparam int CLR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_writer_if bus();

    lcd_writer #(.TICK_DIV(TICK), .POWERUP_STEPS(PWR), .CLEAR_STEPS(CLR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] idx;
        int         gap;
        int         fd;
    } wr_t;

    wr_t        expq[$];
    logic [7:0] tbl[32];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         fd_total = 0;
    int         rw_bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Formatter model: character for the current index, one clock late.
    always @(posedge clk) bus.char_in <= tbl[bus.index];

    task automatic push(input logic rs, input logic [7:0] d, input logic [4:0] idx,
                        input int gap, input int fd);
        wr_t w;
        w.rs = rs; w.data = d; w.idx = idx; w.gap = gap; w.fd = fd;
        expq.push_back(w);
    endtask

    // Whole expected write stream from reset release: init commands, then frames.
    task automatic push_run(input int nframes);
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int i = 0; i < 4; i++)
            push(1'b0, cmds[i], 5'd0, (i == 0) ? PWR * TICK + 1 : TICK, 0);
        for (int f = 0; f < nframes; f++) begin
            push(1'b0, 8'h80, 5'd0, (f == 0) ? (CLR + 1) * TICK : TICK, (f == 0) ? 0 : 1);
            for (int p = 0; p < 32; p++) begin
                if (p == 16) push(1'b0, 8'hC0, 5'd16, TICK, 0);
                push(1'b1, tbl[p], 5'((p + 1) % 32), TICK, 0);
            end
        end
    endtask

    int         cyc      = 0;
    int         hi       = 0;
    int         fd_since = 0;
    logic       e_prev   = 1'b0;
    logic       cap_rs   = 1'b0;
    logic [7:0] cap_data = 8'h00;

    // Monitor: checks every strobe against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cyc = 0; hi = 0; fd_since = 0; e_prev = 1'b0;
            expq.delete();
        end else begin
            cyc++;
            if (bus.lcd_rw !== 1'b0) rw_bad++;
            if (bus.frame_done) begin
                fd_since++;
                fd_total++;
            end
            if (bus.lcd_e && !e_prev) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t w;
                    w = expq.pop_front();
                    check("write_rs",    bus.lcd_rs,   w.rs);
                    check("write_data",  bus.lcd_data, w.data);
                    check("write_index", bus.index,    w.idx);
                    check("write_gap",   cyc,          w.gap);
                    check("frame_done_before_write", fd_since, w.fd);
                end
                cyc = 0; fd_since = 0; hi = 1;
                cap_rs = bus.lcd_rs; cap_data = bus.lcd_data;
            end else if (bus.lcd_e) begin
                hi++;
            end else if (e_prev) begin
                check("strobe_width", hi,           TICK / 2);
                check("rs_stable",    bus.lcd_rs,   cap_rs);
                check("data_stable",  bus.lcd_data, cap_data);
            end
            e_prev = bus.lcd_e;
        end
    end

    task automatic wait_fd(input int target, input string name);
        for (int i = 0; i < 3000 && fd_total < target; i++) @(negedge clk);
        check(name, fd_total, target);
    endtask

    initial begin
        int   base;
        int   target;
        logic found;
        logic ep;

        for (int i = 0; i < 32; i++) tbl[i] = 8'(8'h40 + i);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lcd_e",      bus.lcd_e,      0);
        check("rst_lcd_rs",     bus.lcd_rs,     0);
        check("rst_lcd_rw",     bus.lcd_rw,     0);
        check("rst_lcd_data",   bus.lcd_data,   0);
        check("rst_index",      bus.index,      0);
        check("rst_frame_done", bus.frame_done, 0);

        // Phase 1: ascending characters, three complete frames.
        rst = 1'b0;
        push_run(4);
        base = fd_total;
        wait_fd(base + 3, "three_frames");

        // Reset on the first cycle of a DATA2 strobe.
        target = $urandom_range(18, 31);
        found  = 1'b0;
        ep     = 1'b1;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (bus.lcd_e && !ep && bus.lcd_rs && bus.index == 5'(target)) found = 1'b1;
            ep = bus.lcd_e;
        end
        check("midstrobe_found", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_lcd_e",    bus.lcd_e,    0);
        check("midrst_index",    bus.index,    0);
        check("midrst_lcd_data", bus.lcd_data, 0);
        check("midrst_lcd_rs",   bus.lcd_rs,   0);

        // Phase 2: random characters after a full restart.
        @(negedge clk);
        for (int i = 0; i < 32; i++) tbl[i] = 8'($urandom_range(0, 255));
        rst = 1'b0;
        push_run(3);
        base = fd_total;
        wait_fd(base + 2, "two_frames_after_reset");
        repeat (40) @(negedge clk);
        check("lcd_rw_never_high", rw_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
